// File: rtl/fht_but_seq_if.sv
// Control/address bus between the FHT butterfly sequencer and its RAM/ROM/butterfly datapath.
interface fht_but_seq_if #(
    parameter int N_LOG2 = 8
);
    logic              start;
    logic              busy;
    logic              done;
    logic [3:0]        stage;
    logic              issue;
    logic [N_LOG2-1:0] rd_addr_0, rd_addr_1, rd_addr_2;
    logic [N_LOG2-2:0] w_addr;
    logic              rd_bank;
    logic              wr_en;
    logic [N_LOG2-1:0] wr_addr_0, wr_addr_1;
    logic              wr_bank;
    logic              res_bank;

    modport master (
        output start,
        input  busy, done, stage, issue, rd_addr_0, rd_addr_1, rd_addr_2, w_addr,
               rd_bank, wr_en, wr_addr_0, wr_addr_1, wr_bank, res_bank
    );

    modport slave (
        input  start,
        output busy, done, stage, issue, rd_addr_0, rd_addr_1, rd_addr_2, w_addr,
               rd_bank, wr_en, wr_addr_0, wr_addr_1, wr_bank, res_bank
    );
endinterface

// File: rtl/fht_but_seq.sv
// Radix-2 FHT butterfly address sequencer: walks N_LOG2 stages of N/2 butterflies over
// ping-pong data banks and replays read addresses as write addresses LAT cycles later.
module fht_but_seq #(
    parameter int N_LOG2 = 8,
    parameter int LAT    = 2
) (
    input  logic         clk,
    input  logic         rst,
    fht_but_seq_if.slave bus
);
    localparam int         CW     = N_LOG2 - 1;
    localparam int         DW     = $clog2(LAT + 1);
    localparam logic [3:0] S_LAST = 4'(N_LOG2 - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nx;

    logic [CW-1:0] c;
    logic [DW-1:0] d;
    logic [3:0]    s;
    logic          run_end, drain_end, issue;

    assign run_end   = (c == '1);
    assign drain_end = (d == DW'(LAT - 1));
    assign issue     = (state == RUN);

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = RUN;
            RUN:     if (run_end) state_nx = DRAIN;
            DRAIN:   if (drain_end) state_nx = (s == S_LAST) ? DONE : RUN;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // c wraps to 0 on its own after N/2 ops; s is kept through DONE so the last stage stays visible
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c <= '0;
            d <= '0;
            s <= '0;
        end else begin
            c <= issue ? c + 1'b1 : '0;
            d <= (state == DRAIN) ? d + 1'b1 : '0;
            if (state == IDLE || state == DONE)
                s <= '0;
            else if (state == DRAIN && drain_end && s != S_LAST)
                s <= s + 1'b1;
        end
    end

    logic [N_LOG2-1:0] ck, h, hm, k, base;
    assign ck   = N_LOG2'(c);
    assign h    = N_LOG2'(1) << s;
    assign hm   = h - N_LOG2'(1);
    assign k    = ck & hm;
    assign base = (ck >> s) << (s + 4'd1);

    always_comb begin
        bus.busy      = (state != IDLE);
        bus.done      = (state == DONE);
        bus.stage     = s;
        bus.issue     = issue;
        bus.rd_bank   = 1'b0;
        bus.rd_addr_0 = '0;
        bus.rd_addr_1 = '0;
        bus.rd_addr_2 = '0;
        bus.w_addr    = '0;
        if (issue) begin
            bus.rd_bank   = s[0];
            bus.rd_addr_0 = base + k;
            bus.rd_addr_1 = base + h + k;
            bus.rd_addr_2 = base + h + ((h - k) & hm);
            bus.w_addr    = CW'(k << (S_LAST - s));
        end
    end

    // Write-back delay line; idle slots carry zeros so the write bus is 0 whenever wr_en is low
    logic [LAT:1]      vld_pipe, bank_pipe;
    logic [N_LOG2-1:0] a0_pipe [LAT:1];
    logic [N_LOG2-1:0] a1_pipe [LAT:1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe  <= '0;
            bank_pipe <= '0;
            for (int i = 1; i <= LAT; i++) begin
                a0_pipe[i] <= '0;
                a1_pipe[i] <= '0;
            end
        end else begin
            vld_pipe[1]  <= issue;
            bank_pipe[1] <= issue & ~s[0];
            a0_pipe[1]   <= bus.rd_addr_0;
            a1_pipe[1]   <= bus.rd_addr_1;
            for (int i = 2; i <= LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                bank_pipe[i] <= bank_pipe[i-1];
                a0_pipe[i]   <= a0_pipe[i-1];
                a1_pipe[i]   <= a1_pipe[i-1];
            end
        end
    end

    assign bus.wr_en     = vld_pipe[LAT];
    assign bus.wr_bank   = bank_pipe[LAT];
    assign bus.wr_addr_0 = a0_pipe[LAT];
    assign bus.wr_addr_1 = a1_pipe[LAT];
    assign bus.res_bank  = 1'(N_LOG2 % 2);
endmodule

// File: tb/tb_fht_but_seq.sv
// Bench for fht_but_seq (N=8, LAT=2): timeline model of every output, address table,
// spurious starts, mid-run reset and an impulse pushed through a behavioural RAM/butterfly.
module tb_fht_but_seq;
    localparam int N_LOG2 = 3, LAT = 2, N = 8, HALF = N / 2, PER = HALF + LAT, TOT = N_LOG2 * PER;
    localparam int AMP = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fht_but_seq_if #(.N_LOG2(N_LOG2)) bus ();
    fht_but_seq #(.N_LOG2(N_LOG2), .LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic       busy, done;
        logic [3:0] stage;
        logic       issue;
        logic [2:0] r0, r1, r2;
        logic [1:0] w;
        logic       rb, we;
        logic [2:0] a0, a1;
        logic       wb, res;
    } obs_t;

    typedef struct {int s, c, r0, r1, r2, w, rb;} vec_t;

    int   n_cmp = 0, n_bad = 0;
    int   cyc = 0, base = -1000, done_cnt = 0;
    bit   chk_en = 1'b0;
    obs_t snap [64];
    int   ram [2][N];
    int   y0q[$], y1q[$];

    function automatic obs_t sample();
        obs_t a;
        a.busy = bus.busy;   a.done = bus.done;   a.stage = bus.stage;   a.issue = bus.issue;
        a.r0 = bus.rd_addr_0; a.r1 = bus.rd_addr_1; a.r2 = bus.rd_addr_2; a.w = bus.w_addr;
        a.rb = bus.rd_bank;  a.we = bus.wr_en;    a.a0 = bus.wr_addr_0;  a.a1 = bus.wr_addr_1;
        a.wb = bus.wr_bank;  a.res = bus.res_bank;
        return a;
    endfunction

    // Butterfly op issued at a given cycle offset from the first issue, from stage/group arithmetic
    function automatic bit op_at(input int off, output int s, output int r0, output int r1,
                                 output int r2, output int w);
        int c, h, k, b;
        s = 0; r0 = 0; r1 = 0; r2 = 0; w = 0;
        if (off < 0 || off >= TOT || (off % PER) >= HALF) return 1'b0;
        s  = off / PER;
        c  = off % PER;
        h  = 1 << s;
        k  = c % h;
        b  = (c / h) * 2 * h;
        r0 = b + k;
        r1 = b + h + k;
        r2 = b + h + (h - k) % h;
        w  = k * (N / (2 * h));
        return 1'b1;
    endfunction

    function automatic obs_t model(input int off);
        obs_t e;
        int   s, r0, r1, r2, w;
        e     = '0;
        e.res = 1'(N_LOG2 % 2);
        if (off >= 0 && off <= TOT) begin
            e.busy  = 1'b1;
            e.done  = (off == TOT);
            e.stage = 4'((off == TOT) ? N_LOG2 - 1 : off / PER);
        end
        if (op_at(off, s, r0, r1, r2, w)) begin
            e.issue = 1'b1; e.rb = 1'(s % 2);
            e.r0 = 3'(r0); e.r1 = 3'(r1); e.r2 = 3'(r2); e.w = 2'(w);
        end
        if (op_at(off - LAT, s, r0, r1, r2, w)) begin
            e.we = 1'b1; e.wb = 1'((s + 1) % 2);
            e.a0 = 3'(r0); e.a1 = 3'(r1);
        end
        return e;
    endfunction

    always @(negedge clk) begin
        obs_t a, e;
        int   off, x0, x1, x2;
        real  th, t;
        cyc++;
        a   = sample();
        off = cyc - base;
        if (off >= 0 && off < 64) snap[off] = a;
        if (a.done) done_cnt++;
        if (chk_en) begin
            e = model(off);
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL timeline cyc=%0d off=%0d actual=%h required=%h", cyc, off, a, e);
            end
            n_cmp++;
            if (a.issue && a.we && a.rb == a.wb) begin
                n_bad++;
                $display("FAIL bank_overlap cyc=%0d actual bank=%0d required different banks", cyc, a.rb);
            end
        end
        // behavioural datapath: pre-loaded impulse, butterfly results land LAT cycles after issue
        if (rst) begin
            y0q.delete(); y1q.delete();
        end else begin
            if (bus.wr_en && y0q.size() > 0) begin
                ram[bus.wr_bank][bus.wr_addr_0] = y0q.pop_front();
                ram[bus.wr_bank][bus.wr_addr_1] = y1q.pop_front();
            end
            if (bus.issue) begin
                x0 = ram[bus.rd_bank][bus.rd_addr_0];
                x1 = ram[bus.rd_bank][bus.rd_addr_1];
                x2 = ram[bus.rd_bank][bus.rd_addr_2];
                th = 2.0 * 3.14159265358979 * real'(bus.w_addr) / real'(N);
                t  = real'(x1) * $cos(th) + real'(x2) * $sin(th);
                y0q.push_back(int'((real'(x0) + t) / 2.0));
                y1q.push_back(int'((real'(x0) - t) / 2.0));
            end
        end
        if (!bus.busy) begin
            for (int j = 0; j < N; j++) begin ram[0][j] = 0; ram[1][j] = 0; end
            ram[0][0] = AMP;
        end
        if (a.done) begin
            for (int j = 0; j < N; j++) begin
                n_cmp++;
                if (ram[bus.res_bank][j] > AMP / N + 1 || ram[bus.res_bank][j] < AMP / N - 1) begin
                    n_bad++;
                    $display("FAIL impulse[%0d] actual=%0d required=%0d+-1", j, ram[bus.res_bank][j], AMP / N);
                end
            end
        end
    end

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // mode 0: clean start, 1: random extra starts while busy, 2: extra starts in RUN and DRAIN
    task automatic do_run(input int mode);
        int d0;
        repeat ($urandom_range(0, 4)) @(posedge clk);
        d0 = done_cnt;
        #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        base = cyc + 1;
        for (int i = 0; i < TOT; i++) begin
            @(posedge clk);
            #1 bus.start = (mode == 1) ? ($urandom_range(0, 3) == 0) : (mode == 2 && (i == 1 || i == 4));
        end
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (3) @(posedge clk);
        n_cmp++;
        if (done_cnt - d0 != 1) begin
            n_bad++;
            $display("FAIL done_count mode=%0d actual=%0d required=1", mode, done_cnt - d0);
        end
    endtask

    vec_t tab [8];
    obs_t idle_o;

    initial begin
        int d0;
        bus.start = 1'b0;
        idle_o     = '0;
        idle_o.res = 1'b1;
        tab[0] = '{0, 0, 0, 1, 1, 0, 0};
        tab[1] = '{0, 3, 6, 7, 7, 0, 0};
        tab[2] = '{1, 1, 1, 3, 3, 2, 1};
        tab[3] = '{1, 2, 4, 6, 6, 0, 1};
        tab[4] = '{2, 0, 0, 4, 4, 0, 0};
        tab[5] = '{2, 1, 1, 5, 7, 1, 0};
        tab[6] = '{2, 2, 2, 6, 6, 2, 0};
        tab[7] = '{2, 3, 3, 7, 5, 3, 0};

        #2 check("reset_state", sample(), idle_o);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);

        do_run(0);
        foreach (tab[i]) begin
            obs_t a;
            a = snap[tab[i].s * PER + tab[i].c];
            n_cmp++;
            if (!a.issue || a.r0 != 3'(tab[i].r0) || a.r1 != 3'(tab[i].r1) || a.r2 != 3'(tab[i].r2)
                || a.w != 2'(tab[i].w) || a.rb != 1'(tab[i].rb)) begin
                n_bad++;
                $display("FAIL addr_table s=%0d c=%0d actual=%0d/%0d/%0d w=%0d b=%0d required=%0d/%0d/%0d w=%0d b=%0d",
                         tab[i].s, tab[i].c, a.r0, a.r1, a.r2, a.w, a.rb,
                         tab[i].r0, tab[i].r1, tab[i].r2, tab[i].w, tab[i].rb);
            end
        end

        do_run(2);
        for (int r = 0; r < 4; r++) do_run(1);

        // reset at stage 1, c=1: outputs clear immediately, no done, clean restart afterwards
        d0 = done_cnt;
        #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        base = cyc + 1;
        repeat (PER + 1 - 1) @(posedge clk);
        @(posedge clk);
        #1 chk_en = 1'b0;
        check("pre_reset_s1c1", sample(), model(PER + 1));
        #1 rst = 1'b1;
        #1 check("async_reset", sample(), idle_o);
        repeat (3) @(posedge clk);
        #1 check("held_reset", sample(), idle_o);
        rst  = 1'b0;
        base = cyc - 1000;
        chk_en = 1'b1;
        repeat (LAT + 5) @(posedge clk);
        n_cmp++;
        if (done_cnt != d0) begin
            n_bad++;
            $display("FAIL abort_done actual=%0d required=0", done_cnt - d0);
        end
        do_run(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fht_but_seq.md
FHT_BUT_SEQ -- requirements
Module: fht_but_seq

Interface
REQ-001 Parameter N_LOG2, default 8, meaning log2 of transform length N; legal range 2..12.
REQ-002 Parameter LAT, default 2, meaning cycles from read-address issue to butterfly result valid (RAM read plus butterfly register); legal range 1..8.
REQ-003 iCLK  in  1  single clock; all state on rising edge.
REQ-004 iRESET  in  1  asynchronous, active-high reset.
REQ-005 iSTART  in  1  single-cycle request to run all N_LOG2 stages.
REQ-006 oBUSY  out  1  high from the cycle after an accepted start until oDONE.
REQ-007 oDONE  out  1  single-cycle completion pulse.
REQ-008 oSTAGE  out  4  current stage index s.
REQ-009 oISSUE  out  1  read addresses and twiddle index valid this cycle.
REQ-010 oRD_ADDR_0 / oRD_ADDR_1 / oRD_ADDR_2  out  N_LOG2 each  data RAM read addresses for butterfly inputs x0 / x1 / x2.
REQ-011 oW_ADDR  out  N_LOG2-1  sin/cos ROM index.
REQ-012 oRD_BANK  out  1  ping-pong bank read this stage.
REQ-013 oWR_EN  out  1  butterfly outputs y0/y1 to be written this cycle.
REQ-014 oWR_ADDR_0 / oWR_ADDR_1  out  N_LOG2 each  write addresses for y0 / y1.
REQ-015 oWR_BANK  out  1  bank written.
REQ-016 oRES_BANK  out  1  bank holding the final result; constant N_LOG2 mod 2.

Function
REQ-017 FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN on iSTART; RUN->DRAIN after N/2 issue cycles; DRAIN->RUN (s+1) after LAT cycles if s<N_LOG2-1, else DRAIN->DONE; DONE->IDLE after one cycle.
REQ-018 iSTART is ignored in every state other than IDLE.
REQ-019 In RUN, oISSUE is high every cycle; op counter c runs 0..N/2-1, restarts at 0 each stage.
REQ-020 H = 2^s, k = c mod H, base = (c div H)*2H.
REQ-021 oRD_ADDR_0 = base+k; oRD_ADDR_1 = base+H+k; oRD_ADDR_2 = base+H+((H-k) mod H).
REQ-022 oW_ADDR = k * 2^(N_LOG2-1-s).
REQ-023 oRD_BANK = s[0]; oWR_BANK = ~s[0]. Input data must be pre-loaded, bit-reversed, in bank 0.
REQ-024 oWR_EN, oWR_ADDR_0 and oWR_ADDR_1 equal oISSUE, oRD_ADDR_0 and oRD_ADDR_1 delayed exactly LAT cycles via a shift register; oWR_BANK is delayed alongside.
REQ-025 The DRAIN phase guarantees that the last write of stage s occurs before the first read of stage s+1; no read and write to the same bank ever overlap.
REQ-026 oDONE is high for exactly the DONE cycle, one cycle after the last oWR_EN of stage N_LOG2-1.
REQ-027 Timing: with iSTART sampled at edge t0, the first oISSUE is the cycle after t0; oDONE comes N_LOG2*(N/2+LAT) cycles after the first oISSUE cycle.
REQ-028 When not issuing, address outputs hold 0 and oISSUE is 0; when oWR_EN is 0, write addresses are don't-care but are driven 0.

Reset
REQ-029 iRESET high immediately forces IDLE; c, s and the delay line clear; every output is 0 except oRES_BANK (constant).
REQ-030 Reset mid-run aborts without oDONE; any pending delayed writes are discarded (oWR_EN 0); the next iSTART after release starts again from stage 0.

Verification (N_LOG2=3, LAT=2)
REQ-031 Start pulse -> oISSUE high 4 cycles per stage, with 2-cycle gaps; oDONE exactly 18 cycles after the first issue; oBUSY covers the interval; oRES_BANK=1.
REQ-032 Stage 1, c=2 -> rd addresses 4/6/6, oW_ADDR=0, oRD_BANK=1. Stage 2, c=1 -> 1/5/7, oW_ADDR=1. Stage 2, c=3 -> 3/7/5, oW_ADDR=3.
REQ-033 Every oWR_EN cycle -> write addresses equal the read addresses 0/1 from 2 cycles earlier; oWR_BANK = ~oRD_BANK of that issue; no bank-overlap violation.
REQ-034 iSTART re-pulsed during RUN and during DRAIN -> no effect; cycle counts unchanged.
REQ-035 iRESET asserted at stage 1, c=1 -> all outputs 0 asynchronously and no oDONE; a new start after release repeats REQ-031 exactly.
REQ-036 End-to-end: sequencer, RAMs, ROM and the butterfly on an impulse input -> every output sample is 1/N of the impulse amplitude (each stage halves), within 1 LSB.
